// File: rtl/dht_start_ctrl.sv
// DHT single-wire start sequencer: host-low pulse, release, acknowledge qualification,
// automatic retry with backoff, and hand-off to the bit receiver on a valid acknowledge.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line released, waiting for start
// HOST_LOW | driving the pin low for the mode-selected host-low time
// HOST_REL | line released, settling before looking for the acknowledge
// WAIT_ACK | waiting for the sensor to pull the line low
// ACK_LOW  | measuring the sensor's acknowledge-low phase
// ACK_HIGH | measuring the sensor's acknowledge-high phase
// BACKOFF  | line released between a failed attempt and the retry
// DONE     | single cycle, confirm pulse to the receiver
module dht_start_ctrl #(
   parameter int CNT_W       = 24,
   parameter int T_LOW_DHT11 = 1800000,
   parameter int T_LOW_DHT22 = 100000,
   parameter int T_REL       = 3000,
   parameter int T_WAIT_MAX  = 5000,
   parameter int T_ACK_MIN   = 6000,
   parameter int T_ACK_MAX   = 10000,
   parameter int T_BACKOFF   = 200000,
   parameter int MAX_RETRY   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   input  logic       abort,
   input  logic       dht_in,
   output logic       dht_oe,
   output logic       out_delay,
   output logic       busy,
   output logic       confirm_to_reciver,
   output logic       timeout_err,
   output logic [1:0] retries,
   output logic [2:0] states
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HOST_LOW = 3'd1,
      S_HOST_REL = 3'd2,
      S_WAIT_ACK = 3'd3,
      S_ACK_LOW  = 3'd4,
      S_ACK_HIGH = 3'd5,
      S_BACKOFF  = 3'd6,
      S_DONE     = 3'd7
   } state_t;

   localparam logic [CNT_W-1:0] LP_LOW11_M1 = CNT_W'(T_LOW_DHT11 - 1);
   localparam logic [CNT_W-1:0] LP_LOW22_M1 = CNT_W'(T_LOW_DHT22 - 1);
   localparam logic [CNT_W-1:0] LP_REL_M1   = CNT_W'(T_REL - 1);
   localparam logic [CNT_W-1:0] LP_WAIT_MAX = CNT_W'(T_WAIT_MAX);
   localparam logic [CNT_W-1:0] LP_ACK_MIN  = CNT_W'(T_ACK_MIN);
   localparam logic [CNT_W-1:0] LP_ACK_MAX  = CNT_W'(T_ACK_MAX);
   localparam logic [CNT_W-1:0] LP_BOFF_M1  = CNT_W'(T_BACKOFF - 1);
   localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);
   localparam logic [1:0]       LP_MAX_RTY  = 2'(MAX_RETRY);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mode;
   logic [1:0]       r_retries;
   logic             r_sync1;
   logic             r_sync2;
   logic             r_timeout;
   logic             w_din_s;
   logic             w_fail;
   logic             w_to_pulse;
   logic             w_in_win;
   logic [CNT_W-1:0] w_low_m1;

   assign w_din_s  = r_sync2;
   assign w_low_m1 = r_mode ? LP_LOW22_M1 : LP_LOW11_M1;
   assign w_in_win = (r_cnt >= LP_ACK_MIN) && (r_cnt <= LP_ACK_MAX);

   always_comb begin
      w_next     = r_state;
      w_fail     = 1'b0;
      w_to_pulse = 1'b0;
      case (r_state)
         S_IDLE:     if (start) w_next = S_HOST_LOW;
         S_HOST_LOW: if (r_cnt == w_low_m1) w_next = S_HOST_REL;
         S_HOST_REL: if (r_cnt == LP_REL_M1) w_next = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (!w_din_s)                w_next = S_ACK_LOW;
            else if (r_cnt >= LP_WAIT_MAX) w_fail = 1'b1;
         end
         S_ACK_LOW: begin
            if (w_din_s) begin
               if (w_in_win) w_next = S_ACK_HIGH;
               else          w_fail = 1'b1;
            end else if (r_cnt > LP_ACK_MAX) begin
               w_fail = 1'b1;
            end
         end
         S_ACK_HIGH: begin
            if (!w_din_s) begin
               if (w_in_win) w_next = S_DONE;
               else          w_fail = 1'b1;
            end else if (r_cnt > LP_ACK_MAX) begin
               w_fail = 1'b1;
            end
         end
         S_BACKOFF:  if (r_cnt == LP_BOFF_M1) w_next = S_HOST_LOW;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
      if (w_fail) begin
         if (r_retries < LP_MAX_RTY) begin
            w_next = S_BACKOFF;
         end else begin
            w_next     = S_IDLE;
            w_to_pulse = 1'b1;
         end
      end
      // Abort overrides every in-flight decision, including a pending error pulse.
      if (abort && (r_state != S_IDLE)) begin
         w_next     = S_IDLE;
         w_to_pulse = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_mode    <= 1'b0;
         r_retries <= 2'd0;
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_timeout <= 1'b0;
      end else begin
         r_sync1   <= dht_in;
         r_sync2   <= r_sync1;
         r_state   <= w_next;
         r_timeout <= w_to_pulse;
         if ((w_next != r_state) || (w_next == S_IDLE)) r_cnt <= '0;
         else                                           r_cnt <= r_cnt + LP_ONE;
         if ((r_state == S_IDLE) && (w_next == S_HOST_LOW)) begin
            r_mode    <= mode;
            r_retries <= 2'd0;
         end else if ((r_state == S_BACKOFF) && (w_next == S_HOST_LOW)) begin
            r_retries <= r_retries + 2'd1;
         end
      end
   end

   assign dht_oe             = (r_state == S_HOST_LOW);
   assign out_delay          = ~dht_oe;
   assign busy               = (r_state != S_IDLE);
   assign confirm_to_reciver = (r_state == S_DONE) && !abort;
   assign timeout_err        = r_timeout;
   assign retries            = r_retries;
   assign states             = r_state;

endmodule

// File: tb/tb_dht_start_ctrl.sv
// Directed bench for dht_start_ctrl with shortened timing and a scripted sensor model.
module tb_dht_start_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       abort = 1'b0;
   logic       dht_in = 1'b1;
   logic       dht_oe;
   logic       out_delay;
   logic       busy;
   logic       confirm_to_reciver;
   logic       timeout_err;
   logic [1:0] retries;
   logic [2:0] states;

   int n_chk = 0;
   int n_pass = 0;

   int m_oe = 0, m_conf = 0, m_to = 0, m_both = 0, m_boff = 0;
   int m_wait = 0, m_rel = 0, m_acklo = 0, m_od_bad = 0, m_busy_bad = 0;
   int s_oe, s_conf, s_to, s_boff, s_wait, s_rel, s_acklo;

   dht_start_ctrl #(
      .CNT_W(24), .T_LOW_DHT11(100), .T_LOW_DHT22(20), .T_REL(5),
      .T_WAIT_MAX(10), .T_ACK_MIN(8), .T_ACK_MAX(12), .T_BACKOFF(16), .MAX_RETRY(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort), .dht_in(dht_in),
      .dht_oe(dht_oe), .out_delay(out_delay), .busy(busy),
      .confirm_to_reciver(confirm_to_reciver), .timeout_err(timeout_err),
      .retries(retries), .states(states)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dht_oe)                             m_oe++;
      if (confirm_to_reciver)                 m_conf++;
      if (timeout_err)                        m_to++;
      if (confirm_to_reciver && timeout_err)  m_both++;
      if (states == 3'd6)                     m_boff++;
      if (states == 3'd3)                     m_wait++;
      if (states == 3'd2)                     m_rel++;
      if (states == 3'd4)                     m_acklo++;
      if (out_delay !== ~dht_oe)              m_od_bad++;
      if (busy !== (states != 3'd0))          m_busy_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic snap();
      s_oe = m_oe; s_conf = m_conf; s_to = m_to; s_boff = m_boff;
      s_wait = m_wait; s_rel = m_rel; s_acklo = m_acklo;
   endtask

   task automatic pulse_start(input logic m);
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   // Sensor: after the host releases, wait pre cycles, then low lo, high hi, then a short bit-start low.
   task automatic sensor_ack(input int pre, input int lo, input int hi);
      int n = 0;
      while (!dht_oe && n < 400) begin @(negedge clk); n++; end
      while (dht_oe && n < 400) begin @(negedge clk); n++; end
      if (n >= 400) begin
         chk("sensor_wait_release", 32'd0, 32'd1);
         return;
      end
      repeat (pre) @(negedge clk);
      dht_in = 1'b0;
      repeat (lo) @(negedge clk);
      dht_in = 1'b1;
      repeat (hi) @(negedge clk);
      dht_in = 1'b0;
      repeat (5) @(negedge clk);
      dht_in = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_oe", {31'd0, dht_oe}, 32'd0);
      chk("rst_out_delay", {31'd0, out_delay}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_states", {29'd0, states}, 32'd0);
      chk("rst_retries", {30'd0, retries}, 32'd0);
      chk("rst_pulses", {30'd0, confirm_to_reciver, timeout_err}, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: DHT11 good acknowledge
      snap();
      pulse_start(1'b0);
      chk("s1_oe_rise", {31'd0, dht_oe}, 32'd1);
      sensor_ack(3, 10, 10);
      wait_idle("s1_idle");
      chk("s1_oe_cycles", m_oe - s_oe, 32'd100);
      chk("s1_rel_cycles", m_rel - s_rel, 32'd5);
      chk("s1_confirm", m_conf - s_conf, 32'd1);
      chk("s1_timeout", m_to - s_to, 32'd0);
      chk("s1_retries", {30'd0, retries}, 32'd0);

      // 2: DHT22 good acknowledge
      repeat (3) @(negedge clk);
      snap();
      pulse_start(1'b1);
      sensor_ack(3, 10, 10);
      wait_idle("s2_idle");
      chk("s2_oe_cycles", m_oe - s_oe, 32'd20);
      chk("s2_confirm", m_conf - s_conf, 32'd1);
      chk("s2_retries", {30'd0, retries}, 32'd0);

      // 3: no sensor
      repeat (3) @(negedge clk);
      snap();
      pulse_start(1'b1);
      wait_idle("s3_idle");
      repeat (2) @(negedge clk);
      chk("s3_oe_cycles", m_oe - s_oe, 32'd40);
      chk("s3_backoff", m_boff - s_boff, 32'd16);
      chk("s3_wait_cycles", m_wait - s_wait, 32'd22);
      chk("s3_rel_cycles", m_rel - s_rel, 32'd10);
      chk("s3_timeout", m_to - s_to, 32'd1);
      chk("s3_confirm", m_conf - s_conf, 32'd0);
      chk("s3_retries", {30'd0, retries}, 32'd1);

      // 4: short ack-low, then good retry
      repeat (3) @(negedge clk);
      snap();
      pulse_start(1'b1);
      sensor_ack(3, 5, 10);
      sensor_ack(3, 10, 10);
      wait_idle("s4_idle");
      chk("s4_retries", {30'd0, retries}, 32'd1);
      chk("s4_confirm", m_conf - s_conf, 32'd1);
      chk("s4_timeout", m_to - s_to, 32'd0);
      chk("s4_backoff", m_boff - s_boff, 32'd16);

      // 5: ack-low too long, fails at count 13, then good retry
      repeat (3) @(negedge clk);
      snap();
      pulse_start(1'b1);
      sensor_ack(3, 20, 2);
      chk("s5_acklow_cycles", m_acklo - s_acklo, 32'd14);
      sensor_ack(3, 10, 10);
      wait_idle("s5_idle");
      chk("s5_retries", {30'd0, retries}, 32'd1);
      chk("s5_confirm", m_conf - s_conf, 32'd1);
      chk("s5_timeout", m_to - s_to, 32'd0);

      // 6: abort, stray start while busy, reset mid-HOST_LOW
      repeat (3) @(negedge clk);
      snap();
      pulse_start(1'b0);
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("s6_abort_oe", {31'd0, dht_oe}, 32'd0);
      chk("s6_abort_state", {29'd0, states}, 32'd0);
      chk("s6_abort_busy", {31'd0, busy}, 32'd0);
      pulse_start(1'b0);
      repeat (10) @(negedge clk);
      pulse_start(1'b1);
      repeat (40) @(negedge clk);
      chk("s6_stray_start", {29'd0, states}, 32'd1);
      chk("s6_stray_oe", {31'd0, dht_oe}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("s6_rst_oe", {31'd0, dht_oe}, 32'd0);
      chk("s6_rst_out_delay", {31'd0, out_delay}, 32'd1);
      chk("s6_rst_state", {29'd0, states}, 32'd0);
      chk("s6_rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("s6_no_pulses", (m_conf - s_conf) + (m_to - s_to), 32'd0);

      chk("never_both_pulses", m_both, 32'd0);
      chk("out_delay_inverse", m_od_bad, 32'd0);
      chk("busy_vs_state", m_busy_bad, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dht_start_ctrl.md
Name: dht_start_ctrl

Overview:
Parametrised successor to the single-shot DHT start generator. It drives the DHT single-wire start pulse (host low, then release) for DHT11 or DHT22 timing, selected per request. It then qualifies the sensor's 80/80 µs acknowledge and signals the receiver on success. On failure it retries automatically up to a limit and reports an error once retries are exhausted. It sits between the top-level controller and the bit receiver, owning the open-drain enable of the data pin until the acknowledge completes.

Parameters:
CNT_W, 24, width of the shared duration counter; all T_* must fit in it.
T_LOW_DHT11, 1800000, host-low cycles in mode 0 (18 ms at 100 MHz).
T_LOW_DHT22, 100000, host-low cycles in mode 1 (1 ms).
T_REL, 3000, host-release cycles before sampling for the acknowledge (30 µs).
T_WAIT_MAX, 5000, maximum cycles in WAIT_ACK for the sensor to pull low.
T_ACK_MIN, 6000, minimum valid width of the ack-low and ack-high phases.
T_ACK_MAX, 10000, maximum valid width of the ack-low and ack-high phases.
T_BACKOFF, 200000, released-line cycles between a failure and the retry.
MAX_RETRY, 2, retries after the first attempt (0 = no retry).

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-low reset.
start  in  1  request pulse; sampled only in IDLE.
mode  in  1  0 = DHT11, 1 = DHT22; latched when start is accepted.
abort  in  1  synchronous abort; takes priority over all transitions except reset.
dht_in  in  1  raw data-pin level; asynchronous to clk.
dht_oe  out  1  1 = drive pin low.
out_delay  out  1  line level request, equal to ~dht_oe.
busy  out  1  1 in any state other than IDLE.
confirm_to_reciver  out  1  one-cycle pulse on a valid acknowledge.
timeout_err  out  1  one-cycle pulse when retries are exhausted.
retries  out  2  attempts already retried in the current request.
states  out  3  current state encoding, for debug.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state IDLE; dht_oe=0, out_delay=1, busy=0, confirm_to_reciver=0, timeout_err=0, retries=0, counter=0.
  - The synchroniser flops reset to 1.
  - Reset mid-operation releases the line on that same edge.
- dht_in passes through a 2-flop synchroniser to give din_s. Both edges are delayed equally, so widths are measured on din_s unchanged.
- State encoding: IDLE=0, HOST_LOW=1, HOST_REL=2, WAIT_ACK=3, ACK_LOW=4, ACK_HIGH=5, BACKOFF=6, DONE=7.
- The counter clears on every state entry and increments each cycle in that state.
- IDLE:
  - start=1 latches mode, clears retries and enters HOST_LOW. dht_oe rises on the cycle after start.
  - start while busy is ignored, never queued.
- HOST_LOW: dht_oe=1 for exactly T_LOW (selected by the latched mode) cycles, then HOST_REL.
- HOST_REL: dht_oe=0 for exactly T_REL cycles, then WAIT_ACK. din_s is ignored in this state.
- WAIT_ACK:
  - din_s=0 goes to ACK_LOW.
  - If the counter reaches T_WAIT_MAX first, the attempt fails.
- ACK_LOW, on the cycle din_s=1:
  - counter in [T_ACK_MIN, T_ACK_MAX]: go to ACK_HIGH.
  - otherwise: fail.
  - counter exceeding T_ACK_MAX while din_s is still 0: fail immediately.
- ACK_HIGH: same rule, ending on din_s=0. A valid width goes to DONE.
- DONE lasts 1 cycle: confirm_to_reciver=1, then IDLE. The line stays released so the receiver takes over bit timing.
- Fail:
  - retries < MAX_RETRY: go to BACKOFF (line released for T_BACKOFF cycles), then increment retries and return to HOST_LOW.
  - otherwise: timeout_err=1 for one cycle, then IDLE.
- abort=1 in any non-IDLE state: IDLE on the next edge with dht_oe=0. No error pulse, no confirm.
- confirm_to_reciver and timeout_err are never asserted together.
- busy deasserts on the cycle the state returns to IDLE.

Test Plan:
All scenarios use T_LOW_DHT11=100, T_LOW_DHT22=20, T_REL=5, T_WAIT_MAX=10, T_ACK_MIN=8, T_ACK_MAX=12, T_BACKOFF=16, MAX_RETRY=1.
1. Reset then start, mode=0; model pulls low 3 cycles after release, 10 low, 10 high -> dht_oe high exactly 100 cycles, one confirm pulse, retries=0, busy=0 afterwards.
2. Same with mode=1 -> dht_oe high exactly 20 cycles, confirm pulse.
3. No sensor (dht_in=1 throughout) -> two attempts separated by 16 released cycles, retries=1, single timeout_err pulse, no confirm.
4. First attempt ack-low of 5 cycles (too short), second attempt valid -> retries=1, confirm pulse, no timeout_err.
5. Ack-low held 20 cycles -> fail declared at count 13, before din rises; retry follows.
6. abort during HOST_LOW, then start pulse while busy, then rst=0 mid-HOST_LOW -> abort releases the line next edge with no pulses; the start pulse while busy has no effect; rst returns all outputs to reset values on that edge.
